// File: rtl/drive_cmd_encoder.sv
// Driver push-button front end for the rear-light controller: synchronises and
// debounces five active-low keys and runs the driving-mode FSM that drives state_out.
module drive_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TURN_TIMEOUT    = 500_000_000,
  parameter int DB_W            = 20,
  parameter int TO_W            = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_n,
  output logic [3:0] state_out,
  output logic       mode_chg,
  output logic [4:0] key_stable_n
);

  localparam int NK      = 5;
  localparam int K_STOP  = 0;
  localparam int K_GO    = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_BACK  = 4;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TURN_TIMEOUT - 1);

  // State encodings are the rear-light mode codes, so state_out is the register itself.
  typedef enum logic [3:0] {
    ST_STOP  = 4'b1111,
    ST_GO    = 4'b1110,
    ST_LEFT  = 4'b1101,
    ST_RIGHT = 4'b1011,
    ST_BACK  = 4'b0111
  } mode_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_STOP,
    EV_BACK,
    EV_GO,
    EV_LEFT,
    EV_RIGHT
  } event_e;

  logic [NK-1:0] sync1_n;
  logic [NK-1:0] sync2_n;
  logic [NK-1:0] stable_n;
  logic [NK-1:0] stable_d_n;
  logic [NK-1:0] press;
  logic [DB_W-1:0] db_cnt [NK];

  event_e          ev;
  mode_e           state_q;
  mode_e           state_d;
  mode_e           base_state;
  logic            base_go_q;
  logic            base_go_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            in_turn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value; a
      // blocking chain would collapse the two-flop synchroniser into one flop.
      sync1_n <= key_n;
      sync2_n <= sync1_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-key counter array is ordinary flops, so it is reset like any
      // other register; a true RAM array would not be given a reset.
      for (int i = 0; i < NK; i++) begin
        db_cnt[i] <= '0;
      end
      stable_n   <= '1;
      stable_d_n <= '1;
    end else begin
      stable_d_n <= stable_n;
      for (int i = 0; i < NK; i++) begin
        if (sync2_n[i] != stable_n[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable_n[i] <= sync2_n[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A press is a debounced 1->0 edge; releases are deliberately ignored.
  assign press = stable_d_n & ~stable_n;

  always_comb begin
    ev = EV_NONE;
    if      (press[K_STOP])  ev = EV_STOP;
    else if (press[K_BACK])  ev = EV_BACK;
    else if (press[K_GO])    ev = EV_GO;
    else if (press[K_LEFT])  ev = EV_LEFT;
    else if (press[K_RIGHT]) ev = EV_RIGHT;
  end

  assign base_state = base_go_q ? ST_GO : ST_STOP;
  assign in_turn    = (state_q == ST_LEFT) || (state_q == ST_RIGHT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d   = state_q;
    base_go_d = base_go_q;
    to_cnt_d  = '0;

    case (ev)
      EV_STOP: begin
        state_d   = ST_STOP;
        base_go_d = 1'b0;
      end
      EV_BACK: begin
        case (state_q)
          ST_STOP: state_d = ST_BACK;
          ST_BACK: state_d = ST_BACK;
          default: begin
            state_d   = ST_STOP;
            base_go_d = 1'b0;
          end
        endcase
      end
      EV_GO: begin
        case (state_q)
          ST_GO:   state_d = ST_GO;
          ST_BACK: state_d = ST_STOP;  // reversing must pass through STOP
          default: begin
            state_d   = ST_GO;
            base_go_d = 1'b1;
          end
        endcase
      end
      EV_LEFT: begin
        case (state_q)
          ST_BACK: state_d = ST_BACK;
          ST_LEFT: state_d = base_state;
          default: state_d = ST_LEFT;
        endcase
      end
      EV_RIGHT: begin
        case (state_q)
          ST_BACK:  state_d = ST_BACK;
          ST_RIGHT: state_d = base_state;
          default:  state_d = ST_RIGHT;
        endcase
      end
      default: begin
        if (in_turn && (to_cnt_q == TO_LAST)) begin
          state_d = base_state;
        end
      end
    endcase

    // Entering or swapping turn direction restarts the timeout from zero.
    if (((state_d == ST_LEFT) || (state_d == ST_RIGHT)) && (state_d == state_q)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOP;
      base_go_q <= 1'b0;
      to_cnt_q  <= '0;
      mode_chg  <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_go_q <= base_go_d;
      to_cnt_q  <= to_cnt_d;
      mode_chg  <= (state_d != state_q);
    end
  end

  assign state_out    = state_q;
  assign key_stable_n = stable_n;

endmodule
